// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between multicycle controller and datapath
interface multicycle_controller_if #(
  parameter int OPW  = 5,
  parameter int ALUW = 4
);
  // datapath -> controller
  logic [OPW-1:0]  op;
  logic [ALUW-1:0] funct;
  logic            zero;
  logic            mem_ready;
  // controller -> datapath
  logic            pcen;
  logic            iord;
  logic            memwrite;
  logic            irwrite;
  logic            regdst;
  logic            memtoreg;
  logic            regwrite;
  logic            alusrca;
  logic [1:0]      alusrcb;
  logic [1:0]      pcsrc;
  logic [ALUW-1:0] alucontrol;
  logic            illegal_op;
  logic            instr_done;
  logic [3:0]      state;

  modport master (
    input  op, funct, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, instr_done, state
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, pcsrc, alucontrol, illegal_op, instr_done, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle CPU control FSM with memory-ready handshake
module multicycle_controller #(
  parameter int              OPW     = 5,
  parameter int              ALUW    = 4,
  parameter logic [OPW-1:0]  OP_R    = OPW'(0),
  parameter logic [OPW-1:0]  OP_LW   = OPW'(1),
  parameter logic [OPW-1:0]  OP_SW   = OPW'(2),
  parameter logic [OPW-1:0]  OP_BEQ  = OPW'(3),
  parameter logic [OPW-1:0]  OP_ADDI = OPW'(4),
  parameter logic [OPW-1:0]  OP_J    = OPW'(5),
  parameter logic [ALUW-1:0] ALU_ADD = ALUW'(0),
  parameter logic [ALUW-1:0] ALU_SUB = ALUW'(1)
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_controller_if.master bus
);

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_EXECUTE = 4'd6;
  localparam logic [3:0] S_ALUWB   = 4'd7;
  localparam logic [3:0] S_BRANCH  = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JUMP    = 4'd11;

  logic [3:0]      state_q, state_d;
  logic            pcwrite, branch;
  logic            iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]      alusrcb, pcsrc;
  logic [ALUW-1:0] alucontrol;
  logic            illegal_op, instr_done;

  // Next-state and per-state control decode (Mealy on mem_ready in wait states)
  always_comb begin
    state_d    = state_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    irwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = ALU_ADD;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        alusrcb = 2'b01;
        irwrite = bus.mem_ready;
        pcwrite = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        if (bus.op == OP_LW || bus.op == OP_SW) state_d = S_MEMADR;
        else if (bus.op == OP_R)                state_d = S_EXECUTE;
        else if (bus.op == OP_BEQ)              state_d = S_BRANCH;
        else if (bus.op == OP_ADDI)             state_d = S_ADDIEX;
        else if (bus.op == OP_J)                state_d = S_JUMP;
        else begin
          // unknown opcode: abandon the instruction and refetch
          state_d    = S_FETCH;
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        memwrite   = 1'b1;
        instr_done = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = bus.funct;
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        pcsrc      = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcwrite    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Drive outputs; reset forces everything low so an aborted store drops memwrite at once
  always_comb begin
    if (reset) begin
      bus.pcen       = 1'b0;
      bus.iord       = 1'b0;
      bus.memwrite   = 1'b0;
      bus.irwrite    = 1'b0;
      bus.regdst     = 1'b0;
      bus.memtoreg   = 1'b0;
      bus.regwrite   = 1'b0;
      bus.alusrca    = 1'b0;
      bus.alusrcb    = 2'b00;
      bus.pcsrc      = 2'b00;
      bus.alucontrol = '0;
      bus.illegal_op = 1'b0;
      bus.instr_done = 1'b0;
      bus.state      = 4'd0;
    end else begin
      bus.pcen       = pcwrite | (branch & bus.zero);
      bus.iord       = iord;
      bus.memwrite   = memwrite;
      bus.irwrite    = irwrite;
      bus.regdst     = regdst;
      bus.memtoreg   = memtoreg;
      bus.regwrite   = regwrite;
      bus.alusrca    = alusrca;
      bus.alusrcb    = alusrcb;
      bus.pcsrc      = pcsrc;
      bus.alucontrol = alucontrol;
      bus.illegal_op = illegal_op;
      bus.instr_done = instr_done;
      bus.state      = state_q;
    end
  end

  // State register, asynchronously returned to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  typedef struct packed {
    logic [3:0] state;
    logic       pcen;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] alucontrol;
    logic       illegal_op;
    logic       instr_done;
  } obs_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc_cnt = 0;
  int   last_len = -1;
  obs_t exp_q[$];

  multicycle_controller_if #(.OPW(5), .ALUW(4)) bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // instruction length monitor: cycles from one instr_done (exclusive) to the next (inclusive)
  always @(negedge clk) begin
    if (reset) cyc_cnt = 0;
    else begin
      cyc_cnt = cyc_cnt + 1;
      if (bus.instr_done) begin
        last_len = cyc_cnt;
        cyc_cnt  = 0;
      end
    end
  end

  function automatic obs_t capture();
    obs_t o;
    o.state      = bus.state;
    o.pcen       = bus.pcen;
    o.iord       = bus.iord;
    o.memwrite   = bus.memwrite;
    o.irwrite    = bus.irwrite;
    o.regdst     = bus.regdst;
    o.memtoreg   = bus.memtoreg;
    o.regwrite   = bus.regwrite;
    o.alusrca    = bus.alusrca;
    o.alusrcb    = bus.alusrcb;
    o.pcsrc      = bus.pcsrc;
    o.alucontrol = bus.alucontrol;
    o.illegal_op = bus.illegal_op;
    o.instr_done = bus.instr_done;
    return o;
  endfunction

  // expected outputs for a given state, straight from the per-state control table
  function automatic obs_t expect_for(input logic [3:0] st, input logic mr, input logic z,
                                      input logic [4:0] opc, input logic [3:0] fn);
    obs_t e = '0;
    e.state = st;
    case (st)
      4'd0:  begin e.alusrcb = 2'b01; e.irwrite = mr; e.pcen = mr; end
      4'd1:  begin
        e.alusrcb = 2'b11;
        if (opc > 5'd5) begin e.illegal_op = 1'b1; e.instr_done = 1'b1; end
      end
      4'd2:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd3:  e.iord = 1'b1;
      4'd4:  begin e.memtoreg = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1; end
      4'd5:  begin e.iord = 1'b1; e.memwrite = 1'b1; e.instr_done = mr; end
      4'd6:  begin e.alusrca = 1'b1; e.alucontrol = fn; end
      4'd7:  begin e.regdst = 1'b1; e.regwrite = 1'b1; e.instr_done = 1'b1; end
      4'd8:  begin
        e.alusrca = 1'b1; e.alucontrol = 4'd1; e.pcsrc = 2'b01;
        e.instr_done = 1'b1; e.pcen = z;
      end
      4'd9:  begin e.alusrca = 1'b1; e.alusrcb = 2'b10; end
      4'd10: begin e.regwrite = 1'b1; e.instr_done = 1'b1; end
      4'd11: begin e.pcsrc = 2'b10; e.pcen = 1'b1; e.instr_done = 1'b1; end
      default: e = '0;
    endcase
    return e;
  endfunction

  // one clock cycle: entered at posedge+1, drives inputs, checks at negedge, leaves at next posedge+1
  task automatic cyc(input string tag, input logic [3:0] st, input logic mr, input logic z);
    obs_t got, e;
    bus.mem_ready = mr;
    bus.zero      = z;
    exp_q.push_back(expect_for(st, mr, z, bus.op, bus.funct));
    @(negedge clk);
    got = capture();
    e   = exp_q.pop_front();
    checks++;
    assert (got === e) else begin
      failures++;
      $error("FAIL %s: got=%h exp=%h", tag, got, e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_len(input string tag, input int want);
    checks++;
    assert (last_len === want) else begin
      failures++;
      $error("FAIL %s: cycles got=%0d exp=%0d", tag, last_len, want);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    obs_t got;
    got = capture();
    checks++;
    assert (got === obs_t'(0)) else begin
      failures++;
      $error("FAIL %s: got=%h exp=%h", tag, got, obs_t'(0));
    end
  endtask

  initial begin
    bus.op        = 5'd0;
    bus.funct     = 4'b1111;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b1;
    reset         = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    reset = 1'b0;

    // LW, no stalls
    bus.op = 5'd1;
    cyc("lw_fetch", 4'd0, 1'b1, 1'b0);
    cyc("lw_decode", 4'd1, 1'b1, 1'b0);
    cyc("lw_memadr", 4'd2, 1'b1, 1'b0);
    cyc("lw_memrd", 4'd3, 1'b1, 1'b0);
    cyc("lw_memwb", 4'd4, 1'b1, 1'b0);
    check_len("lw_cpi", 5);

    // R-type with funct 0110
    bus.op = 5'd0; bus.funct = 4'b0110;
    cyc("r_fetch", 4'd0, 1'b1, 1'b1);
    cyc("r_decode", 4'd1, 1'b1, 1'b1);
    cyc("r_execute", 4'd6, 1'b1, 1'b1);
    cyc("r_aluwb", 4'd7, 1'b1, 1'b1);
    check_len("r_cpi", 4);

    // BEQ taken
    bus.op = 5'd3; bus.funct = 4'b0000;
    cyc("beq1_fetch", 4'd0, 1'b1, 1'b1);
    cyc("beq1_decode", 4'd1, 1'b1, 1'b1);
    cyc("beq1_branch", 4'd8, 1'b1, 1'b1);
    check_len("beq1_cpi", 3);

    // BEQ not taken
    cyc("beq0_fetch", 4'd0, 1'b1, 1'b0);
    cyc("beq0_decode", 4'd1, 1'b1, 1'b0);
    cyc("beq0_branch", 4'd8, 1'b1, 1'b0);
    check_len("beq0_cpi", 3);

    // J
    bus.op = 5'd5;
    cyc("j_fetch", 4'd0, 1'b1, 1'b0);
    cyc("j_decode", 4'd1, 1'b1, 1'b0);
    cyc("j_jump", 4'd11, 1'b1, 1'b0);
    check_len("j_cpi", 3);

    // ADDI with three fetch stalls
    bus.op = 5'd4;
    for (int i = 0; i < 3; i++) cyc("addi_fetch_wait", 4'd0, 1'b0, 1'b1);
    cyc("addi_fetch", 4'd0, 1'b1, 1'b1);
    cyc("addi_decode", 4'd1, 1'b1, 1'b1);
    cyc("addi_ex", 4'd9, 1'b1, 1'b1);
    cyc("addi_wb", 4'd10, 1'b1, 1'b1);
    check_len("addi_stall_cpi", 7);

    // SW with two write stalls
    bus.op = 5'd2;
    cyc("sw_fetch", 4'd0, 1'b1, 1'b0);
    cyc("sw_decode", 4'd1, 1'b1, 1'b0);
    cyc("sw_memadr", 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cyc("sw_memwr_wait", 4'd5, 1'b0, 1'b0);
    cyc("sw_memwr", 4'd5, 1'b1, 1'b0);
    check_len("sw_stall_cpi", 6);

    // illegal opcode
    bus.op = 5'd31;
    cyc("ill_fetch", 4'd0, 1'b1, 1'b1);
    cyc("ill_decode", 4'd1, 1'b1, 1'b1);
    check_len("ill_cpi", 2);
    cyc("ill_next_fetch", 4'd0, 1'b0, 1'b1);

    // LW with one read stall
    bus.op = 5'd1;
    cyc("lws_fetch", 4'd0, 1'b1, 1'b0);
    cyc("lws_decode", 4'd1, 1'b1, 1'b0);
    cyc("lws_memadr", 4'd2, 1'b1, 1'b0);
    cyc("lws_memrd_wait", 4'd3, 1'b0, 1'b0);
    cyc("lws_memrd", 4'd3, 1'b1, 1'b0);
    cyc("lws_memwb", 4'd4, 1'b1, 1'b0);
    check_len("lw_stall_cpi", 7);

    // reset asserted while a store waits in MEMWR
    bus.op = 5'd2;
    cyc("rst_sw_fetch", 4'd0, 1'b1, 1'b1);
    cyc("rst_sw_decode", 4'd1, 1'b1, 1'b1);
    cyc("rst_sw_memadr", 4'd2, 1'b1, 1'b1);
    cyc("rst_sw_memwr", 4'd5, 1'b0, 1'b1);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset_memwr");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held_edge");
    reset = 1'b0;
    bus.op = 5'd5;
    cyc("post_rst_fetch", 4'd0, 1'b1, 1'b0);
    cyc("post_rst_decode", 4'd1, 1'b1, 1'b0);
    cyc("post_rst_jump", 4'd11, 1'b1, 1'b0);
    check_len("post_rst_cpi", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Parametrised multicycle successor to the single-cycle control unit: a Moore/Mealy FSM that sequences each instruction over 3–5+ cycles through fetch, decode, execute, memory and writeback. It drives the shared-memory, shared-ALU multicycle datapath, adds a memory-ready handshake for variable-latency memory, decodes an R-type function field, and flags illegal opcodes. It sits beside the datapath in the multicycle CPU top level, replacing the main-decoder/ALU-decoder/branch-AND trio.

## Interface
Parameters:
- OPW, 5, opcode width
- ALUW, 4, ALU control / funct width
- OP_R, 5'd0; OP_LW, 5'd1; OP_SW, 5'd2; OP_BEQ, 5'd3; OP_ADDI, 5'd4; OP_J, 5'd5: opcode encodings
- ALU_ADD, 4'd0; ALU_SUB, 4'd1: ALU codes used by non-R states

Ports:
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high
- op  input  OPW  opcode from instruction register
- funct  input  ALUW  R-type function field (used directly as ALU control)
- zero  input  1  ALU zero flag
- mem_ready  input  1  memory completes access this cycle
- pcen  output  1  PC write enable = pcwrite | (branch & zero)
- iord  output  1  memory address mux: 0 = PC, 1 = ALUOut
- memwrite  output  1  memory write strobe
- irwrite  output  1  instruction register load
- regdst  output  1  write-register mux: 1 = rd
- memtoreg  output  1  writeback mux: 1 = memory data
- regwrite  output  1  register file write enable
- alusrca  output  1  ALU A: 0 = PC, 1 = reg A
- alusrcb  output  2  ALU B: 00 = reg B, 01 = constant 4, 10 = sign-ext imm, 11 = imm<<2
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alucontrol  output  ALUW  ALU operation
- illegal_op  output  1  one-cycle pulse on unknown opcode
- instr_done  output  1  one-cycle pulse on the last cycle of every instruction
- state  output  4  current state encoding (debug)

## Operation
- States (encodings 0–11): FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Unlisted outputs are 0 in every state.
- FETCH: iord=0, alusrca=0, alusrcb=01, alucontrol=ALU_ADD, pcsrc=00. irwrite=pcwrite=mem_ready (Mealy). Stays in FETCH while mem_ready=0; otherwise goes to DECODE.
- DECODE: alusrca=0, alusrcb=11, alucontrol=ALU_ADD (branch target into ALUOut). Next state by op:
  - OP_LW/OP_SW → MEMADR
  - OP_R → EXECUTE
  - OP_BEQ → BRANCH
  - OP_ADDI → ADDIEX
  - OP_J → JUMP
  - any other op → FETCH, with illegal_op=1 and instr_done=1 that cycle.
- MEMADR: alusrca=1, alusrcb=10, ALU_ADD. Next state: LW → MEMRD, SW → MEMWR.
- MEMRD: iord=1. Waits for mem_ready, then → MEMWB.
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1. → FETCH.
- MEMWR: iord=1, memwrite=1 held until mem_ready. instr_done=mem_ready. → FETCH on mem_ready.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol=funct. → ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1. → FETCH.
- BRANCH: alusrca=1, alusrcb=00, alucontrol=ALU_SUB, branch=1, pcsrc=01, instr_done=1. → FETCH.
- ADDIEX: alusrca=1, alusrcb=10, ALU_ADD. → ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1. → FETCH.
- JUMP: pcsrc=10, pcwrite=1, instr_done=1. → FETCH.
- pcen = pcwrite | (branch & zero), combinational; zero is sampled in the same cycle.

## Timing
- reset asserted: state=FETCH immediately (asynchronous). All outputs are forced to 0 while reset=1, including pcen and alucontrol.
- First FETCH is evaluated in the first clk edge after reset falls.
- CPI with mem_ready held at 1: LW 5, SW 4, R 4, ADDI 4, BEQ 3, J 3, illegal 2.
- Each wait cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- During a wait, outputs stay stable and irwrite/pcwrite stay 0.
- reset mid-instruction: aborts the instruction. No pulse is issued on instr_done or illegal_op, and memwrite drops asynchronously.
- op and funct must be stable from DECODE to the end of the instruction; the IR is frozen because irwrite=0 outside FETCH.

## Test plan
- Reset: assert reset mid-MEMWR (memwrite=1) → memwrite=0 and state=0 without a clock edge. Release, then mem_ready=1 → irwrite=pcen=1 on the first cycle.
- LW with mem_ready=1: op=1 → states 0,1,2,3,4. regwrite=1 and memtoreg=1 only in MEMWB; instr_done pulses once; 5 cycles total.
- R-type: op=0, funct=4'b0110 → alucontrol=4'b0110 in EXECUTE. ALUWB has regdst=1 and regwrite=1; 4 cycles.
- BEQ: op=3 with zero=1 → pcen=1, pcsrc=01, alucontrol=ALU_SUB in BRANCH. Repeat with zero=0 → pcen=0; 3 cycles either way.
- Memory stalls: mem_ready=0 for 3 cycles in FETCH, then SW with mem_ready=0 for 2 cycles in MEMWR. State holds with irwrite=0 and memwrite held at 1; totals are 7 and 6 cycles respectively.
- Illegal op=5'd31: illegal_op=1 and instr_done=1 for exactly one cycle in DECODE. Next state is FETCH; regwrite, memwrite and pcen stay 0.
